// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side push handshake and execute-side decoded head bundle
interface decode_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instruction;
  logic [7:0] pc;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] pc_out;
  logic [7:0] imm;
  logic [7:0] br_target;
  logic [2:0] alu_op;
  logic       is_alu;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_halt;
  logic       illegal;
  modport master (
    output in_valid, instruction, pc, flush, out_ready,
    input  in_ready, out_valid, opcode, operand, pc_out, imm, br_target, alu_op,
           is_alu, is_load, is_store, is_branch, is_halt, illegal
  );
  modport slave (
    input  in_valid, instruction, pc, flush, out_ready,
    output in_ready, out_valid, opcode, operand, pc_out, imm, br_target, alu_op,
           is_alu, is_load, is_store, is_branch, is_halt, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: decodes 8-bit instructions into a 2-entry elastic buffer; HALT stops intake until flush
module decode_stage (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [7:0] pc;
    logic [7:0] imm;
    logic [7:0] br_target;
    logic [2:0] alu_op;
    logic       is_alu;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_halt;
    logic       illegal;
  } entry_t;
  typedef enum logic {RUN, HALTED} state_t;
  state_t     state;
  entry_t     mem [2];
  entry_t     dec;
  entry_t     head;
  logic       rp;
  logic       wp;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic [3:0] op;
  assign op = bus.instruction[7:4];
  always_comb begin
    dec           = '0;
    dec.opcode    = op;
    dec.operand   = bus.instruction[3:0];
    dec.pc        = bus.pc;
    dec.imm       = {4'd0, bus.instruction[3:0]};
    dec.br_target = bus.pc + {{4{bus.instruction[3]}}, bus.instruction[3:0]};
    dec.is_alu    = op >= 4'd1 && op <= 4'd6;
    dec.alu_op    = op == 4'd1 ? 3'd5 : dec.is_alu ? 3'(op - 4'd2) : 3'd0;
    dec.is_load   = op == 4'd7;
    dec.is_store  = op == 4'd8;
    dec.is_branch = op == 4'd9 || op == 4'd10;
    dec.illegal   = op >= 4'd11 && op <= 4'd14;
    dec.is_halt   = op == 4'd15;
  end
  assign bus.in_ready  = !reset && state == RUN && count < 2'd2;
  assign bus.out_valid = count != 2'd0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  assign head = bus.out_valid ? mem[rp] : '0;
  assign bus.opcode    = head.opcode;
  assign bus.operand   = head.operand;
  assign bus.pc_out    = head.pc;
  assign bus.imm       = head.imm;
  assign bus.br_target = head.br_target;
  assign bus.alu_op    = head.alu_op;
  assign bus.is_alu    = head.is_alu;
  assign bus.is_load   = head.is_load;
  assign bus.is_store  = head.is_store;
  assign bus.is_branch = head.is_branch;
  assign bus.is_halt   = head.is_halt;
  assign bus.illegal   = head.illegal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      count <= 2'd0;
      rp    <= 1'b0;
      wp    <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      state <= RUN;
      count <= 2'd0;
      rp    <= 1'b0;
      wp    <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= dec;
        wp      <= ~wp;
        if (dec.is_halt) state <= HALTED;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode vectors plus directed handshake, HALT and flush sequences
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] br;
    logic [2:0] alu;
    logic [5:0] flags;
  } vec_t;
  vec_t vt [14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [5:0] flags();
    return {bus.is_alu, bus.is_load, bus.is_store, bus.is_branch, bus.is_halt, bus.illegal};
  endfunction
  task automatic chk_head(input string name, input vec_t v);
    logic [7:0] b;
    b = v.instr;
    chk({name, " out_valid"}, 32'(bus.out_valid), 1);
    chk({name, " opcode"}, 32'(bus.opcode), 32'(b[7:4]));
    chk({name, " operand"}, 32'(bus.operand), 32'(b[3:0]));
    chk({name, " imm"}, 32'(bus.imm), 32'(b[3:0]));
    chk({name, " pc_out"}, 32'(bus.pc_out), 32'(v.pc));
    chk({name, " br_target"}, 32'(bus.br_target), 32'(v.br));
    chk({name, " alu_op"}, 32'(bus.alu_op), 32'(v.alu));
    chk({name, " flags"}, 32'(flags()), 32'(v.flags));
  endtask
  task automatic chk_idle(input string name);
    chk({name, " out_valid"}, 32'(bus.out_valid), 0);
    chk({name, " data zero"}, {bus.opcode, bus.operand, bus.pc_out, bus.br_target, bus.alu_op, flags()}, 0);
  endtask
  task automatic drive(input logic v, input logic [7:0] i, input logic [7:0] p, input logic r);
    bus.in_valid = v;
    bus.instruction = i;
    bus.pc = p;
    bus.out_ready = r;
  endtask
  function automatic vec_t mk(input logic [7:0] i, input logic [7:0] p, input logic [7:0] br,
                              input logic [2:0] a, input logic [5:0] f);
    vec_t v;
    v.instr = i; v.pc = p; v.br = br; v.alu = a; v.flags = f;
    return v;
  endfunction
  initial begin
    // flags order: alu, load, store, branch, halt, illegal
    vt[0]  = mk(8'h11, 8'h00, 8'h01, 3'd5, 6'b100000);
    vt[1]  = mk(8'h22, 8'h01, 8'h03, 3'd0, 6'b100000);
    vt[2]  = mk(8'h9E, 8'h05, 8'h03, 3'd0, 6'b000100);
    vt[3]  = mk(8'h97, 8'hFC, 8'h03, 3'd0, 6'b000100);
    vt[4]  = mk(8'hC5, 8'h20, 8'h25, 3'd0, 6'b000001);
    vt[5]  = mk(8'h71, 8'h30, 8'h31, 3'd0, 6'b010000);
    vt[6]  = mk(8'h82, 8'h31, 8'h33, 3'd0, 6'b001000);
    vt[7]  = mk(8'h33, 8'h40, 8'h43, 3'd1, 6'b100000);
    vt[8]  = mk(8'h4A, 8'h40, 8'h3A, 3'd2, 6'b100000);
    vt[9]  = mk(8'h5B, 8'h00, 8'hFB, 3'd3, 6'b100000);
    vt[10] = mk(8'h6C, 8'h10, 8'h0C, 3'd4, 6'b100000);
    vt[11] = mk(8'h00, 8'h7F, 8'h7F, 3'd0, 6'b000000);
    vt[12] = mk(8'hA8, 8'h10, 8'h08, 3'd0, 6'b000100);
    vt[13] = mk(8'hBF, 8'h02, 8'h01, 3'd0, 6'b000001);
    bus.flush = 1'b0;
    drive(1'b1, 8'h11, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 0);
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    chk("post-reset in_ready", 32'(bus.in_ready), 1);
    // back-to-back 0x11, 0x22 with out_ready held high
    @(negedge clk);
    drive(1'b1, 8'h11, 8'h00, 1'b1);
    @(negedge clk);
    chk_head("seq first", vt[0]);
    drive(1'b1, 8'h22, 8'h01, 1'b1);
    @(negedge clk);
    chk_head("seq second", vt[1]);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    chk_idle("seq drained");
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, vt[k].instr, vt[k].pc, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      chk($sformatf("vec%0d in_ready", k), 32'(bus.in_ready), 1);
      chk_head($sformatf("vec%0d", k), vt[k]);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk_idle($sformatf("vec%0d popped", k));
    end
    // backpressure: fill, then drain in order while the third waits
    drive(1'b1, 8'h71, 8'h30, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h82, 8'h31, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h33, 8'h40, 1'b0);
    #1;
    chk("full in_ready", 32'(bus.in_ready), 0);
    chk_head("bp head", vt[5]);
    bus.out_ready = 1'b1;
    #1;
    chk("full pop no pass-through", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk_head("bp second", vt[6]);
    chk("bp in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    chk_head("bp third", vt[7]);
    @(negedge clk);
    chk_idle("bp drained");
    // HALT stops intake until flush
    drive(1'b1, 8'hF0, 8'h50, 1'b1);
    @(negedge clk);
    chk("halt is_halt", 32'(bus.is_halt), 1);
    chk("halt opcode", 32'(bus.opcode), 32'hF);
    chk("halt in_ready", 32'(bus.in_ready), 0);
    drive(1'b1, 8'h11, 8'h00, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("halted in_ready", 32'(bus.in_ready), 0);
      chk_idle("halted");
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("unhalt in_ready", 32'(bus.in_ready), 1);
    chk_idle("unhalt");
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    chk_head("unhalt accept", vt[0]);
    @(negedge clk);
    chk_idle("unhalt drained");
    // flush with full buffer and a waiting push
    drive(1'b1, 8'h22, 8'h01, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h33, 8'h40, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    drive(1'b1, 8'h44, 8'h00, 1'b0);
    @(negedge clk);
    bus.flush = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk_idle("flush full");
    // flush at count 1 with an acceptable push: the pushed byte is dropped
    drive(1'b1, 8'h5B, 8'h00, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    drive(1'b1, 8'h44, 8'h00, 1'b1);
    @(negedge clk);
    bus.flush = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    repeat (2) begin
      chk_idle("flush drop");
      @(negedge clk);
    end
    drive(1'b1, 8'h6C, 8'h10, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk_head("after flush", vt[10]);
    // reset mid-operation clears entries and HALTED
    drive(1'b1, 8'hF0, 8'h50, 1'b0);
    @(negedge clk);
    chk("pre-reset halted", 32'(bus.in_ready), 0);
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("mid reset in_ready", 32'(bus.in_ready), 0);
    chk_idle("mid reset");
    reset = 1'b0;
    #1;
    chk("after reset in_ready", 32'(bus.in_ready), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage sitting directly downstream of the fetch stage. Accepts 8-bit instructions with their PC over a valid/ready handshake, decodes the 4-bit opcode and 4-bit operand into control fields, and computes branch targets. Decoded results are held in a 2-entry elastic buffer that feeds the execute stage. A HALT state machine stops intake once HALT is accepted.

## Interface
- DEPTH, 2, buffer entries (fixed at 2; count width 2 bits)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- instruction  in  8  [7:4] opcode, [3:0] operand
- pc  in  8  address of instruction
- flush  in  1  synchronous squash of all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- opcode  out  4  head opcode
- operand  out  4  head operand, also used as register index
- pc_out  out  8  head PC
- imm  out  8  zero-extended operand
- br_target  out  8  pc + sign-extended operand, mod 256
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS-IMM
- is_alu, is_load, is_store, is_branch, is_halt, illegal  out  1 each  control flags

## Operation
- Opcode map: 0 NOP; 1 LDI (is_alu, alu_op 5); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (2–6 set is_alu, alu_op 0–4); 7 LD (is_load); 8 ST (is_store); 9 JMP; A BZ (9/A set is_branch); B–E illegal; F HALT (is_halt).
- Unused flags are 0. alu_op is 0 for non-ALU opcodes. br_target is computed for every opcode.
- Decode happens on the push path. Each entry stores the full decoded result, not the raw byte.
- Push: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- in_ready = !reset && state==RUN && count<2. It depends on no other input.
- No pass-through when full: a simultaneous pop does not free a slot in that cycle.
- Push and pop at the same edge with count=1: count stays 1, FIFO order is preserved.
- Data outputs show the head entry while out_valid=1 and are all 0 while out_valid=0.
- State machine:
  - RUN → HALTED when a HALT (opcode F) is pushed. The HALT entry itself is still delivered downstream.
  - HALTED → RUN only on flush or reset.
- Illegal opcodes are passed downstream with illegal=1. They do not halt.

## Timing
- Reset:
  - count=0, state=RUN, all entries cleared.
  - out_valid=0 and all data outputs 0.
  - in_ready=0 while reset is high and 1 in the first cycle after it drops.
- Latency: an instruction pushed at edge N appears with out_valid=1 in the cycle after edge N, provided the buffer was empty.
- Throughput: 1 instruction per cycle when out_ready is held at 1.
- Flush:
  - At the edge where flush=1: count goes to 0, any simultaneous push is dropped, any pop is irrelevant, and state goes to RUN.
  - out_valid=0 in the next cycle.
- Reset takes priority over flush. Flush takes priority over push and pop.
- Reset mid-operation discards all entries and the HALTED state at that edge.
- Width rules:
  - br_target = (pc + {{4{operand[3]}}, operand}) mod 256. Wrap-around is required.
  - count never exceeds 2 and never underflows; a pop with count 0 is impossible because out_valid=0.

## Test plan
- Reset, then push 0x11 at pc 0x00 and 0x22 at pc 0x01 with out_ready=1:
  - Cycle after first push: opcode 1, operand 1, alu_op 5, is_alu 1, imm 0x01.
  - Next cycle: opcode 2, alu_op 0, pc_out 0x01.
- Branch arithmetic:
  - Push 0x9E at pc 0x05 → is_branch 1, br_target 0x03.
  - Push 0x97 at pc 0xFC → br_target 0x03 (wrap).
- Backpressure: out_ready=0, in_valid=1 with 0x71, 0x82, 0x33.
  - First two accepted; in_ready=0 after the second.
  - Raise out_ready: 0x71 (is_load) then 0x82 (is_store) delivered in order, then 0x33 is accepted.
- HALT: push 0xF0 then 0x11 continuously.
  - 0xF0 delivered with is_halt 1; in_ready stays 0 and 0x11 is never accepted.
  - Pulse flush → in_ready=1 the next cycle, and 0x11 is accepted.
- Flush with full buffer and a simultaneous push: out_valid=0 the next cycle, and the pushed byte never appears at the output.
- Illegal: push 0xC5 → illegal 1, all other flags 0, in_ready stays 1.
